// File: rtl/rsa_byte_loader.sv
// Byte-stream wrapper for the RSA exponent core: loads N, M, E, starts the core, then streams the result out LSB-first.
// Optional busy-rise timeout with sticky err is built when RSA_BYTE_LOADER_TIMEOUT_EN is defined.
module rsa_byte_loader #(
    parameter int OP_BYTES      = 32,
    parameter int BUSY_WAIT_MAX = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       rsa_we_n,
    output logic       rsa_start_n,
    output logic [1:0] rsa_reg_sel,
    output logic [4:0] rsa_addr,
    output logic [7:0] rsa_data,
    input  logic [7:0] rsa_data_o,
    input  logic       rsa_busy,
    output logic       err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO,
        S_RD_ADDR,
        S_RD_WAIT,
        S_RD_CAP,
        S_OUT
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(OP_BYTES - 1);

    state_t     r_state;
    logic [4:0] r_cnt;
    logic [1:0] r_seg;

`ifdef RSA_BYTE_LOADER_TIMEOUT_EN
    localparam int WAIT_W = $clog2(BUSY_WAIT_MAX + 1);
    logic [WAIT_W-1:0] r_wait_cnt;
`else
    // The timeout limit has no effect when the timeout logic is not built.
    logic w_unused_cfg;
    assign w_unused_cfg = (BUSY_WAIT_MAX > 0);
`endif

    // Operand order N, M, E maps onto the core's register-select codes.
    function automatic logic [1:0] seg_to_sel(input logic [1:0] seg);
        case (seg)
            2'd0:    return 2'd3;
            2'd1:    return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_seg       <= '0;
            in_ready    <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            rsa_we_n    <= 1'b1;
            rsa_start_n <= 1'b1;
            rsa_reg_sel <= '0;
            rsa_addr    <= '0;
            rsa_data    <= '0;
            err         <= 1'b0;
`ifdef RSA_BYTE_LOADER_TIMEOUT_EN
            r_wait_cnt  <= '0;
`endif
        end else begin
            // NOTE: strobes default high here and the state that needs a pulse overrides
            // them below; the last non-blocking assignment in the block takes effect.
            rsa_we_n    <= 1'b1;
            rsa_start_n <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_cnt    <= '0;
                    r_seg    <= '0;
                    in_ready <= 1'b1;
                    r_state  <= S_LOAD;
                end
                S_LOAD: begin
                    if (in_valid && in_ready) begin
                        rsa_we_n    <= 1'b0;
                        rsa_reg_sel <= seg_to_sel(r_seg);
                        rsa_addr    <= r_cnt;
                        rsa_data    <= in_data;
                        if (r_cnt == LAST_IDX) begin
                            r_cnt <= '0;
                            if (r_seg == 2'd2) begin
                                in_ready <= 1'b0;
                                r_state  <= S_START;
                            end else begin
                                r_seg <= r_seg + 2'd1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                S_START: begin
                    rsa_start_n <= 1'b0;
                    r_state     <= S_WAIT_HI;
`ifdef RSA_BYTE_LOADER_TIMEOUT_EN
                    r_wait_cnt  <= '0;
`endif
                end
                S_WAIT_HI: begin
                    if (rsa_busy) begin
                        r_state <= S_WAIT_LO;
`ifdef RSA_BYTE_LOADER_TIMEOUT_EN
                    end else if (r_wait_cnt == WAIT_W'(BUSY_WAIT_MAX)) begin
                        err     <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
`endif
                    end
                end
                S_WAIT_LO: begin
                    if (!rsa_busy) begin
                        r_cnt       <= '0;
                        rsa_we_n    <= 1'b0;
                        rsa_reg_sel <= 2'd0;
                        rsa_addr    <= '0;
                        r_state     <= S_RD_ADDR;
                    end
                end
                S_RD_ADDR: r_state <= S_RD_WAIT;
                S_RD_WAIT: r_state <= S_RD_CAP;
                S_RD_CAP: begin
                    out_data  <= rsa_data_o;
                    out_valid <= 1'b1;
                    r_state   <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (r_cnt == LAST_IDX) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt    <= r_cnt + 5'd1;
                            rsa_we_n <= 1'b0;
                            rsa_addr <= r_cnt + 5'd1;
                            r_state  <= S_RD_ADDR;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_byte_loader.sv
// Self-checking bench for rsa_byte_loader: a behavioural core model logs writes and serves result bytes.
`timescale 1ns/1ps
module tb_rsa_byte_loader;

`ifdef RSA_BYTE_LOADER_TIMEOUT_EN
    localparam int BWM = 15;
`else
    localparam int BWM = 1023;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       rsa_we_n;
    logic       rsa_start_n;
    logic [1:0] rsa_reg_sel;
    logic [4:0] rsa_addr;
    logic [7:0] rsa_data;
    logic [7:0] rsa_data_o;
    logic       rsa_busy = 1'b0;
    logic       err;

    always #5 clk = ~clk;

    rsa_byte_loader #(.OP_BYTES(32), .BUSY_WAIT_MAX(BWM)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .rsa_we_n(rsa_we_n), .rsa_start_n(rsa_start_n), .rsa_reg_sel(rsa_reg_sel),
        .rsa_addr(rsa_addr), .rsa_data(rsa_data), .rsa_data_o(rsa_data_o),
        .rsa_busy(rsa_busy), .err(err)
    );

    localparam logic [27:0] RST_VEC = {1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 5'd0, 8'h00, 1'b0};

    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  op_mem  [96];
    logic [7:0]  res_mem [32];
    logic [14:0] wr_arr  [2048];
    int          wr_count = 0;
    int          start_cnt = 0;

    // Core model: logs operand writes, returns result[addr] one cycle after a read strobe.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rsa_data_o <= 8'h00;
        end else begin
            if (!rsa_we_n && rsa_reg_sel != 2'd0) begin
                wr_arr[wr_count] <= {rsa_reg_sel, rsa_addr, rsa_data};
                wr_count <= wr_count + 1;
            end
            if (!rsa_we_n && rsa_reg_sel == 2'd0) rsa_data_o <= res_mem[rsa_addr];
            if (!rsa_start_n) start_cnt <= start_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] outs();
        return {in_ready, out_valid, out_data, rsa_we_n, rsa_start_n, rsa_reg_sel, rsa_addr, rsa_data, err};
    endfunction

    function automatic logic [1:0] exp_sel(input int seg);
        return (seg == 0) ? 2'd3 : (seg == 1) ? 2'd1 : 2'd2;
    endfunction

    task automatic fill_random_ops();
        for (int i = 0; i < 96; i++) op_mem[i] = 8'($urandom);
    endtask

    task automatic fill_results(input bit ramp);
        for (int k = 0; k < 32; k++) res_mem[k] = ramp ? 8'(k + 8'h40) : 8'($urandom);
    endtask

    task automatic load_ops(input bit gaps);
        int i = 0;
        int b = 0;
        int stray = 0;
        while (i < 96 && b < 1000) begin
            in_valid = 1'b1;
            in_data  = op_mem[i];
            if (out_valid) stray++;
            if (in_ready) begin
                tick();
                i++;
                if (gaps) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    tick();
                end
            end else begin
                tick();
            end
            b++;
        end
        in_valid = 1'b0;
        check("load_count", i, 96);
        check("no_stray_out", stray, 0);
        check("in_ready_drop", in_ready, 0);
    endtask

    task automatic wait_start();
        int b = 0;
        while (rsa_start_n !== 1'b0 && b < 50) begin
            tick();
            b++;
        end
        check("start_pulse", rsa_start_n, 0);
    endtask

    task automatic check_writes(input int wb);
        check("wr_count", wr_count - wb, 96);
        for (int i = 0; i < 96; i++)
            check($sformatf("wr%0d", i), {17'd0, wr_arr[wb + i]}, {17'd0, exp_sel(i / 32), 5'(i % 32), op_mem[i]});
    endtask

    task automatic busy_phase(input int n_hi);
        rsa_busy = 1'b1;
        repeat (n_hi) tick();
        rsa_busy = 1'b0;
        tick();
        check("rd_strobe", {rsa_we_n, rsa_reg_sel, rsa_addr}, 8'h00);
        tick();
        tick();
        check("rd_latency_early", out_valid, 0);
        tick();
        check("rd_latency", out_valid, 1);
    endtask

    task automatic collect(input int stall_idx, input bit rnd_ready, input bit hold, input logic [7:0] hold_byte);
        int k = 0;
        int b = 0;
        int stalled = 0;
        int bad_ready = 0;
        int wb;
        wb = wr_count;
        while (k < 32 && b < 2000) begin
            if (hold) begin
                in_valid = 1'b1;
                in_data  = hold_byte;
                if (in_ready) bad_ready++;
            end
            if (out_valid && k == stall_idx && stalled < 5) begin
                out_ready = 1'b0;
                check("stall_hold", out_data, res_mem[k]);
                stalled++;
            end else begin
                out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_valid && out_ready) begin
                    check($sformatf("out%0d", k), out_data, res_mem[k]);
                    k++;
                end
            end
            tick();
            b++;
        end
        out_ready = 1'b0;
        check("out_count", k, 32);
        if (hold) begin
            check("in_ready_low_rd", bad_ready, 0);
            check("no_wr_rd", wr_count - wb, 0);
        end
    endtask

    task automatic run_txn(input bit gaps, input bit busy_pre, input int n_hi, input int stall_idx,
                           input bit rnd_ready, input bit hold, input logic [7:0] hold_byte);
        int wb;
        int sb;
        wb = wr_count;
        sb = start_cnt;
        load_ops(gaps);
        if (busy_pre) rsa_busy = 1'b1;
        wait_start();
        check_writes(wb);
        busy_phase(n_hi);
        collect(stall_idx, rnd_ready, hold, hold_byte);
        check("start_count", start_cnt - sb, 1);
    endtask

    initial begin
        logic [7:0] hold_byte;

        // Reset values, then IDLE lasts one cycle before LOAD raises in_ready.
        repeat (2) tick();
        check("reset_outs", outs(), RST_VEC);
        reset = 1'b0;
        check("ready_after_rst", in_ready, 0);
        tick();
        check("idle_one_cycle", in_ready, 1);

        // Directed operands N=0xFB, M=0x05, E=0x03; result ramp 0x40..0x5F.
        for (int i = 0; i < 96; i++) op_mem[i] = 8'h00;
        op_mem[0]  = 8'hFB;
        op_mem[32] = 8'h05;
        op_mem[64] = 8'h03;
        fill_results(1'b1);
        run_txn(1'b0, 1'b0, 10, -1, 1'b0, 1'b0, 8'h00);

        // Input gaps, out_ready held low for five cycles on byte 7.
        fill_random_ops();
        fill_results(1'b1);
        run_txn(1'b1, 1'b0, 6, 7, 1'b0, 1'b0, 8'h00);

        // Reset asserted while waiting for busy to fall.
        fill_random_ops();
        load_ops(1'b0);
        wait_start();
        rsa_busy = 1'b1;
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outs", outs(), RST_VEC);
        rsa_busy = 1'b0;
        repeat (2) tick();
        check("held_reset_outs", outs(), RST_VEC);
        reset = 1'b0;

        // Fresh load after the abort, random data and random backpressure.
        fill_random_ops();
        fill_results(1'b0);
        run_txn(1'b0, 1'b0, 4, -1, 1'b1, 1'b0, 8'h00);

        // Busy already high on the start cycle, falling one cycle later.
        fill_random_ops();
        fill_results(1'b0);
        run_txn(1'b0, 1'b1, 1, -1, 1'b0, 1'b0, 8'h00);

        // in_valid held high throughout readout; the pending byte opens the next load.
        fill_random_ops();
        fill_results(1'b0);
        hold_byte = 8'($urandom);
        run_txn(1'b1, 1'b0, 3, -1, 1'b1, 1'b1, hold_byte);
        fill_random_ops();
        op_mem[0] = hold_byte;
        fill_results(1'b0);
        run_txn(1'b0, 1'b0, 2, -1, 1'b0, 1'b0, 8'h00);

`ifdef RSA_BYTE_LOADER_TIMEOUT_EN
        // Busy never rises: err at 16 cycles after start, back to LOAD the next cycle.
        fill_random_ops();
        load_ops(1'b0);
        wait_start();
        repeat (15) tick();
        check("err_before_limit", err, 0);
        tick();
        check("err_at_limit", err, 1);
        check("timeout_no_ready", in_ready, 0);
        check("timeout_no_out", out_valid, 0);
        tick();
        check("timeout_reload", in_ready, 1);
        fill_random_ops();
        fill_results(1'b0);
        run_txn(1'b0, 1'b0, 5, -1, 1'b0, 1'b0, 8'h00);
        check("err_sticky", err, 1);
`else
        check("err_tied_low", err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
